// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first: one full-adder cell plus a carry flop.
// Returns a registered sum with carry-out and signed-overflow flags and a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_sr_q, res_sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               bit_s;
    logic               carry_s;
    logic               last_bit_s;
    logic [WIDTH-1:0]   res_shift_s;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder cell operating on the current LSBs and the carry flop
    assign bit_s       = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign carry_s     = majority(a_sr_q[0], b_sr_q[0], c_q);
    assign last_bit_s  = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_shift_s = {bit_s, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift_s;
                c_d      = carry_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit_s) begin
                    // Overflow: carry into the MSB differs from carry out of it
                    sum_d   = res_shift_s;
                    cout_d  = carry_s;
                    ovf_d   = c_q ^ carry_s;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): drivers push expected results,
// a negedge monitor pops and compares on every done pulse, including latency.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int unsigned  due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("done_while_busy", {63'd0, busy}, 64'd0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with sum=0x%0h, expected no done (cycle %0d)", sum, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sum",     {56'd0, sum},  {56'd0, mon_e.s});
                    chk("cout",    {63'd0, cout}, {63'd0, mon_e.co});
                    chk("ovf",     {63'd0, ovf},  {63'd0, mon_e.ov});
                    chk("latency", {32'd0, cyc},  {32'd0, mon_e.due});
                end
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                mon_e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_done: got no done by cycle %0d, expected done at cycle %0d", cyc, mon_e.due);
            end
        end
    end

    // Must be called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input bit push, input logic [W-1:0] es, input logic eco,
                         input logic eov, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got busy=1 after 100 cycles, expected busy=0");
        end
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        if (push) sb.push_back('{es, eco, eov, cyc + 1 + W});
        @(negedge clk);
        start = 1'b0;
        a     = ~ia;
        b     = W'($urandom);
        cin   = ~ic;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_sum"},  {56'd0, sum},  64'd0);
        chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
        chk({tag, "_ovf"},  {63'd0, ovf},  64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rov;
        logic [W:0]   t;
        int           guard;

        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results
        issue(8'h35, 8'h4A, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1);
        issue(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 0);
        issue(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 2);
        issue(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 0);

        // start mid-RUN must be ignored; then back-to-back from the DONE cycle
        issue(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 0);

        // Reset mid-RUN aborts and clears everything asynchronously
        issue(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_cleared("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1);

        // Regression against an arithmetic reference model
        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            t   = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rov = (ra[W-1] == rb[W-1]) && (t[W-1] != ra[W-1]);
            issue(ra, rb, rc, 1'b1, t[W-1:0], t[W], rov, int'($urandom_range(0, 3)));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first. It is the additive counterpart to the team's subtractor cells and sits in the same arithmetic datapath library.
- Operands are latched on a start handshake and summed one bit per clock through a single full-adder cell and a carry flip-flop.
- Results are returned with a one-cycle done pulse, carry-out and signed-overflow flags.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edge
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in, latched with the operands
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH
- cout  output  1  unsigned carry-out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: rst_n low forces, asynchronously:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0
  - internal shift registers, carry flop and bit counter all cleared.
- Reset mid-operation aborts the addition; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge latches a, b into shift registers and cin into the carry flop, clears the bit counter, and moves to RUN.
- RUN:
  - busy=1.
  - Each edge: bit = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c); a_sr and b_sr shift right; bit enters the result shift register at its MSB; counter increments.
  - On the edge processing bit WIDTH-1: capture ovf = (carry into this bit) XOR (carry out), and move to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - sum = result shift register, cout = final carry.
  - Next state is IDLE unless start=1, in which case new operands are latched and the next state is RUN (back-to-back operation).
- start during RUN is ignored; the operands and the in-flight result are not disturbed.
- Latency: start sampled at edge E -> done high in the cycle after edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum, cout and ovf are registered, update only on entry to DONE, and hold until the next DONE or reset.
- Changes on a, b and cin outside the start-sampling edge have no effect.
- cin=1 is handled identically to a carry from a lower bit; there are no special cases.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulsed at edge E -> busy high edges E..E+7, done pulse after edge E+8, sum=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Start with 0x10+0x20; pulse start with a=0xAA, b=0x55 at edge E+3 -> ignored, result sum=0x30. Hold start high in the DONE cycle with 0x01+0x02 -> second done exactly 9 cycles after the first, sum=0x03.
- Assert rst_n low mid-RUN (edge E+4) -> outputs immediately 0, no done pulse, state IDLE. Release reset, start 0x0F+0x01 -> sum=0x10 after 8 cycles.
- Random regression, 1000 operand/cin triples, with start gaps of 0..3 cycles -> sum/cout/ovf match a reference model every done. done is never asserted while busy=1.
